// File: rtl/spi_cfg_seq.sv
// ---------------------------------------------------------------------------
// spi_cfg_seq
// Register-configuration sequencer placed in front of the 9-bit-address /
// 16-bit-data SPI master used for CMOS sensor setup. Walks an external
// (addr, data) table, issues level-held write (and optionally read-back)
// commands, waits for the master's one-cycle done pulses, retries a
// mismatching entry a bounded number of times, and reports completion or
// a classified error.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_start              one-cycle pulse, accepted in IDLE or ERR
//   i_verify_en          read-back compare enable, latched on accepted start
//   o_tbl_idx            table read index
//   i_tbl_addr/_data     table entry at o_tbl_idx (combinational ROM)
//   o_cmd_write/_read    level commands to the SPI master
//   o_spi_addr/_wdata    register address / write data to the SPI master
//   i_write_done/_read_done  one-cycle done pulses from the SPI master
//   i_spi_rdata          read-back data, valid on the i_read_done cycle
//   o_busy               high from accepted start until DONE/ERR
//   o_cfg_done           one-cycle success pulse
//   o_cfg_err            error level, cleared by the next accepted start
//   o_err_code           01 timeout, 10 verify mismatch, 00 none
//   o_err_idx            table index where the error occurred
// ---------------------------------------------------------------------------
module spi_cfg_seq #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 9,
    parameter int NUM_REGS  = 32,
    parameter int IDX_W     = 5,
    parameter int GAP_CYC   = 8,
    parameter int TIMEOUT   = 4095,
    parameter int TO_W      = 12,
    parameter int RETRY_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_verify_en,
    output logic [IDX_W-1:0]  o_tbl_idx,
    input  logic [ADDR_W-1:0] i_tbl_addr,
    input  logic [DATA_W-1:0] i_tbl_data,
    output logic              o_cmd_write,
    output logic              o_cmd_read,
    output logic [ADDR_W-1:0] o_spi_addr,
    output logic [DATA_W-1:0] o_spi_wdata,
    input  logic              i_write_done,
    input  logic              i_read_done,
    input  logic [DATA_W-1:0] i_spi_rdata,
    output logic              o_busy,
    output logic              o_cfg_done,
    output logic              o_cfg_err,
    output logic [1:0]        o_err_code,
    output logic [IDX_W-1:0]  o_err_idx
);

    localparam int RT_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WR, S_GAP_W, S_RD, S_GAP_R, S_CHECK, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t            r_state,    w_stateNxt;
    logic [IDX_W-1:0]  r_idx,      w_idxNxt;
    logic [ADDR_W-1:0] r_spiAddr,  w_spiAddrNxt;
    logic [DATA_W-1:0] r_spiWdata, w_spiWdataNxt;
    logic [DATA_W-1:0] r_rdata,    w_rdataNxt;
    logic              r_cmdWrite, w_cmdWriteNxt;
    logic              r_cmdRead,  w_cmdReadNxt;
    logic              r_busy,     w_busyNxt;
    logic              r_cfgDone,  w_cfgDoneNxt;
    logic              r_cfgErr,   w_cfgErrNxt;
    logic [1:0]        r_errCode,  w_errCodeNxt;
    logic [IDX_W-1:0]  r_errIdx,   w_errIdxNxt;
    logic              r_verify,   w_verifyNxt;
    logic [RT_W-1:0]   r_retry,    w_retryNxt;
    logic [TO_W-1:0]   r_cnt,      w_cntNxt;

    // One counter serves both as the command timeout and the inter-command
    // gap timer; it is cleared on every entry to WR, RD, GAP_W and GAP_R.
    logic w_toHit;
    logic w_gapEnd;
    assign w_toHit  = (r_cnt == TO_W'(TIMEOUT - 1));
    assign w_gapEnd = (r_cnt == TO_W'(GAP_CYC - 1));

    // Next-state and next-output logic. Every output is a register, so the
    // command lines rise one cycle after entering WR/RD and fall the cycle
    // after the done pulse (or the timeout) is seen.
    always_comb begin
        w_stateNxt    = r_state;
        w_idxNxt      = r_idx;
        w_spiAddrNxt  = r_spiAddr;
        w_spiWdataNxt = r_spiWdata;
        w_rdataNxt    = r_rdata;
        w_cmdWriteNxt = 1'b0;
        w_cmdReadNxt  = 1'b0;
        w_busyNxt     = r_busy;
        w_cfgDoneNxt  = 1'b0;
        w_cfgErrNxt   = r_cfgErr;
        w_errCodeNxt  = r_errCode;
        w_errIdxNxt   = r_errIdx;
        w_verifyNxt   = r_verify;
        w_retryNxt    = r_retry;
        w_cntNxt      = r_cnt;

        case (r_state)
            S_IDLE, S_ERR: begin
                if (i_start) begin
                    w_stateNxt   = S_FETCH;
                    w_idxNxt     = '0;
                    w_busyNxt    = 1'b1;
                    w_cfgErrNxt  = 1'b0;
                    w_errCodeNxt = 2'b00;
                    w_retryNxt   = '0;
                    w_verifyNxt  = i_verify_en;
                end
            end
            S_FETCH: begin
                w_spiAddrNxt  = i_tbl_addr;
                w_spiWdataNxt = i_tbl_data;
                if (&i_tbl_addr) begin
                    w_stateNxt   = S_DONE;
                    w_busyNxt    = 1'b0;
                    w_cfgDoneNxt = 1'b1;
                end else begin
                    w_stateNxt = S_WR;
                    w_cntNxt   = '0;
                end
            end
            S_WR: begin
                if (!r_cmdWrite) begin
                    w_cmdWriteNxt = 1'b1;
                end else if (i_write_done) begin
                    w_stateNxt = S_GAP_W;
                    w_cntNxt   = '0;
                end else if (w_toHit) begin
                    w_stateNxt   = S_ERR;
                    w_busyNxt    = 1'b0;
                    w_cfgErrNxt  = 1'b1;
                    w_errCodeNxt = 2'b01;
                    w_errIdxNxt  = r_idx;
                end else begin
                    w_cmdWriteNxt = 1'b1;
                    w_cntNxt      = r_cnt + 1'b1;
                end
            end
            S_GAP_W: begin
                if (w_gapEnd) begin
                    w_stateNxt = r_verify ? S_RD : S_NEXT;
                    w_cntNxt   = '0;
                end else begin
                    w_cntNxt = r_cnt + 1'b1;
                end
            end
            S_RD: begin
                if (!r_cmdRead) begin
                    w_cmdReadNxt = 1'b1;
                end else if (i_read_done) begin
                    w_rdataNxt = i_spi_rdata;
                    w_stateNxt = S_GAP_R;
                    w_cntNxt   = '0;
                end else if (w_toHit) begin
                    w_stateNxt   = S_ERR;
                    w_busyNxt    = 1'b0;
                    w_cfgErrNxt  = 1'b1;
                    w_errCodeNxt = 2'b01;
                    w_errIdxNxt  = r_idx;
                end else begin
                    w_cmdReadNxt = 1'b1;
                    w_cntNxt     = r_cnt + 1'b1;
                end
            end
            S_GAP_R: begin
                if (w_gapEnd) begin
                    w_stateNxt = S_CHECK;
                    w_cntNxt   = '0;
                end else begin
                    w_cntNxt = r_cnt + 1'b1;
                end
            end
            S_CHECK: begin
                if (r_rdata == r_spiWdata) begin
                    w_stateNxt = S_NEXT;
                    w_retryNxt = '0;
                end else if (r_retry >= RT_W'(RETRY_MAX)) begin
                    w_stateNxt   = S_ERR;
                    w_busyNxt    = 1'b0;
                    w_cfgErrNxt  = 1'b1;
                    w_errCodeNxt = 2'b10;
                    w_errIdxNxt  = r_idx;
                end else begin
                    w_stateNxt = S_WR;
                    w_retryNxt = r_retry + 1'b1;
                    w_cntNxt   = '0;
                end
            end
            S_NEXT: begin
                if (r_idx == IDX_W'(NUM_REGS - 1)) begin
                    w_stateNxt   = S_DONE;
                    w_busyNxt    = 1'b0;
                    w_cfgDoneNxt = 1'b1;
                end else begin
                    w_stateNxt = S_FETCH;
                    w_idxNxt   = r_idx + 1'b1;
                end
            end
            S_DONE: begin
                w_stateNxt = S_IDLE;
            end
            default: begin
                w_stateNxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the commands immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_spiAddr  <= '0;
            r_spiWdata <= '0;
            r_rdata    <= '0;
            r_cmdWrite <= 1'b0;
            r_cmdRead  <= 1'b0;
            r_busy     <= 1'b0;
            r_cfgDone  <= 1'b0;
            r_cfgErr   <= 1'b0;
            r_errCode  <= 2'b00;
            r_errIdx   <= '0;
            r_verify   <= 1'b0;
            r_retry    <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_stateNxt;
            r_idx      <= w_idxNxt;
            r_spiAddr  <= w_spiAddrNxt;
            r_spiWdata <= w_spiWdataNxt;
            r_rdata    <= w_rdataNxt;
            r_cmdWrite <= w_cmdWriteNxt;
            r_cmdRead  <= w_cmdReadNxt;
            r_busy     <= w_busyNxt;
            r_cfgDone  <= w_cfgDoneNxt;
            r_cfgErr   <= w_cfgErrNxt;
            r_errCode  <= w_errCodeNxt;
            r_errIdx   <= w_errIdxNxt;
            r_verify   <= w_verifyNxt;
            r_retry    <= w_retryNxt;
            r_cnt      <= w_cntNxt;
        end
    end

    assign o_tbl_idx   = r_idx;
    assign o_cmd_write = r_cmdWrite;
    assign o_cmd_read  = r_cmdRead;
    assign o_spi_addr  = r_spiAddr;
    assign o_spi_wdata = r_spiWdata;
    assign o_busy      = r_busy;
    assign o_cfg_done  = r_cfgDone;
    assign o_cfg_err   = r_cfgErr;
    assign o_err_code  = r_errCode;
    assign o_err_idx   = r_errIdx;

endmodule
